// File: rtl/nn_pkg.sv
// nn_pkg: shared types and constants for the perceptron load sequencer
package nn_pkg;
  localparam int N_PARAMS = 24;
  localparam int N_INPUTS = 4;
  localparam int PAW = $clog2(N_PARAMS);
  localparam int IAW = $clog2(N_INPUTS);
  localparam int FIELDS_PER_NEURON = 6;
  localparam int W0 = 0;
  localparam int W1 = 1;
  localparam int W2 = 2;
  localparam int W3 = 3;
  localparam int B = 4;
  localparam int TH = 5;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_P = 3'd1,
    LOAD_I = 3'd2,
    EVAL   = 3'd3,
    DONE   = 3'd4
  } state_t;
  function automatic logic [PAW-1:0] param_index(input int neuron, input int field);
    return PAW'(neuron * FIELDS_PER_NEURON + field);
  endfunction
endpackage

// File: rtl/nn_byte_writer.sv
// nn_byte_writer: registered write port with a shared load counter
module nn_byte_writer import nn_pkg::*; #(
  parameter int DW = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic wr,
  input  logic sel_p,
  input  logic [DW-1:0] data_in,
  output logic param_we,
  output logic in_we,
  output logic [PAW-1:0] addr,
  output logic [PAW-1:0] count,
  output logic [DW-1:0] wr_data
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      param_we <= 1'b0;
      in_we <= 1'b0;
      addr <= '0;
      count <= '0;
      wr_data <= '0;
    end else begin
      param_we <= wr && sel_p;
      in_we <= wr && !sel_p;
      addr <= wr ? count : addr;
      wr_data <= wr ? data_in : wr_data;
      count <= clr ? '0 : wr ? count + PAW'(1) : count;
    end
endmodule

// File: rtl/nn_load_sequencer.sv
// nn_load_sequencer: command FSM streaming parameter and input bytes into the perceptron array
module nn_load_sequencer import nn_pkg::*; #(
  parameter int DW = 8,
  parameter int EVAL_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [DW-1:0] data_in,
  input  logic data_valid,
  input  logic cmd_load,
  input  logic cmd_run,
  input  logic result_ack,
  output logic param_we,
  output logic [PAW-1:0] param_addr,
  output logic in_we,
  output logic [IAW-1:0] in_addr,
  output logic [DW-1:0] wr_data,
  output logic capture,
  output logic busy,
  output logic params_ok,
  output logic result_valid,
  output logic err,
  output logic [2:0] state
);
  state_t st, st_n;
  logic [3:0] settle, settle_n;
  logic ok_n, rv_n, cap_n, clr, wr, load_acc, err_set;
  logic [PAW-1:0] count;
  assign busy = st inside {LOAD_P, LOAD_I, EVAL};
  assign wr = data_valid && (st == LOAD_P || st == LOAD_I);
  assign state = st;
  assign in_addr = param_addr[IAW-1:0];
  assign load_acc = cmd_load && (st == IDLE || st == DONE);
  assign err_set = (data_valid && !wr) || ((cmd_load || cmd_run) && busy)
                || (cmd_run && !cmd_load && st == IDLE && !params_ok);
  nn_byte_writer #(.DW(DW)) u_writer (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .wr(wr),
    .sel_p(st == LOAD_P),
    .data_in(data_in),
    .param_we(param_we),
    .in_we(in_we),
    .addr(param_addr),
    .count(count),
    .wr_data(wr_data)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      settle <= '0;
      params_ok <= 1'b0;
      result_valid <= 1'b0;
      capture <= 1'b0;
      err <= 1'b0;
    end else begin
      st <= st_n;
      settle <= settle_n;
      params_ok <= ok_n;
      result_valid <= rv_n;
      capture <= cap_n;
      err <= load_acc ? 1'b0 : err | err_set;
    end
  // capture is registered, so it lands one cycle after the settle count reaches zero
  always_comb begin
    st_n = st;
    settle_n = settle;
    ok_n = params_ok;
    rv_n = result_valid;
    cap_n = 1'b0;
    clr = 1'b0;
    case (st)
      IDLE:
        if (cmd_load) begin
          st_n = LOAD_P;
          clr = 1'b1;
          ok_n = 1'b0;
        end else if (cmd_run && params_ok) begin
          st_n = LOAD_I;
          clr = 1'b1;
        end
      LOAD_P:
        if (wr && count == PAW'(N_PARAMS - 1)) begin
          st_n = IDLE;
          ok_n = 1'b1;
        end
      LOAD_I:
        if (wr && count == PAW'(N_INPUTS - 1)) begin
          st_n = EVAL;
          settle_n = 4'(EVAL_CYCLES);
        end
      EVAL:
        if (settle == '0) begin
          st_n = DONE;
          cap_n = 1'b1;
          rv_n = 1'b1;
        end else
          settle_n = settle - 4'd1;
      DONE:
        if (cmd_load) begin
          st_n = LOAD_P;
          clr = 1'b1;
          ok_n = 1'b0;
          rv_n = 1'b0;
        end else if (cmd_run) begin
          st_n = LOAD_I;
          clr = 1'b1;
          rv_n = 1'b0;
        end else if (result_ack) begin
          st_n = IDLE;
          rv_n = 1'b0;
        end
      default: st_n = IDLE;
    endcase
  end
endmodule

// File: doc/nn_load_sequencer.md
Name: nn_load_sequencer

Overview:
- Control FSM for the 4-neuron perceptron array.
- Accepts a byte stream from the ui_in pins, qualified by a one-cycle strobe, and writes it into the parameter bank: 24 bytes, 4 neurons x {w0,w1,w2,w3,bias,threshold}.
- Then loads the 4 network input bytes, waits a fixed settle time for the combinational perceptrons, and issues a capture strobe to the output register.
- Replaces the free-running state counter; sits between the pad interface and register_parameters / shift_register_inputs.

Parameters:
- DW, 8, data byte width.
- N_PARAMS, 24, parameter bytes per full load; index width PAW = clog2(N_PARAMS) = 5.
- N_INPUTS, 4, network input bytes per run; index width IAW = 2.
- EVAL_CYCLES, 2, settle cycles between last input write and capture; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  DW  byte from the pads.
- data_valid  in  1  one-cycle strobe; data_in is valid this cycle.
- cmd_load  in  1  pulse: begin a parameter load.
- cmd_run  in  1  pulse: begin an input load plus evaluation.
- result_ack  in  1  pulse: clear result_valid.
- param_we  out  1  parameter-bank write enable.
- param_addr  out  PAW  parameter index 0..23; index = neuron*6 + field.
- in_we  out  1  input-register write enable.
- in_addr  out  IAW  input index 0..3.
- wr_data  out  DW  registered copy of data_in.
- capture  out  1  one-cycle strobe: latch neuron outputs.
- busy  out  1  high in LOAD_P, LOAD_I and EVAL.
- params_ok  out  1  a complete parameter set has been loaded.
- result_valid  out  1  captured result available.
- err  out  1  sticky protocol error.
- state  out  3  current FSM state encoding, for debug.

Behaviour:
- Reset (async assert, sync release): state=IDLE, all counters 0, and every output 0. This includes params_ok, result_valid and err.
- States: IDLE=0, LOAD_P=1, LOAD_I=2, EVAL=3, DONE=4.
- IDLE + cmd_load -> LOAD_P: byte counter cleared, params_ok cleared on the same edge.
- IDLE + cmd_run:
  - params_ok=1 -> LOAD_I, counter cleared.
  - params_ok=0 -> stay IDLE, set err.
- Both commands in the same cycle: cmd_load wins, no err.
- LOAD_P:
  - Each data_valid: registered write, so param_we=1, param_addr=count, wr_data=data_in appear in the cycle after the strobe. Then count increments.
  - After the write of index N_PARAMS-1: params_ok=1 on that same edge, and the FSM returns to IDLE.
- LOAD_I:
  - Each data_valid produces an in_we write with the same 1-cycle latency; in_addr=count.
  - After index N_INPUTS-1: go to EVAL, settle counter loaded with EVAL_CYCLES.
- EVAL:
  - Counter decrements each cycle.
  - At 0: capture=1 for exactly one cycle, result_valid set, go to DONE.
  - Capture occurs EVAL_CYCLES+1 cycles after the last in_we.
- DONE:
  - result_ack clears result_valid and returns to IDLE.
  - cmd_run in DONE is equivalent to ack followed by a run (direct to LOAD_I); result_valid clears.
  - cmd_load in DONE clears result_valid and goes to LOAD_P.
- data_valid in IDLE, EVAL or DONE: ignored, no write, set err.
- cmd_load or cmd_run while busy: ignored, set err.
- Abort: cmd_load and cmd_run are not aborts. Only rst_n aborts.
  - Reset mid-load leaves params_ok=0.
  - A write pending in the output register is discarded.
- err clears only on reset or on acceptance of cmd_load.
- Strobes are assumed already synchronous and single-cycle. Edge detection is outside this block.
- param_we and in_we are never high in the same cycle. Neither is ever high outside the cycle after an accepted data_valid.

Decomposition:
- Package nn_pkg holds:
  - state enum localparams (IDLE..DONE);
  - N_PARAMS and N_INPUTS;
  - FIELDS_PER_NEURON=6;
  - field offset constants W0=0, W1=1, W2=2, W3=3, B=4, TH=5.
- Sub-module nn_byte_writer: registered write port (we, addr, data) with a load-counter reset input, shared by LOAD_P and LOAD_I.
- The FSM and settle counter stay in the top module.

Test Plan:
- Reset, then cmd_load and 24 strobes with data = index+0x10.
  - Expect 24 param_we pulses, addr 0..23 and data 0x10..0x27, each 1 cycle after its strobe.
  - After the last write: params_ok=1, state=IDLE, err=0.
- With params_ok=1: cmd_run and inputs 0x01,0x02,0x03,0x04.
  - Expect in_addr 0..3, then capture exactly 3 cycles after the last in_we (EVAL_CYCLES=2).
  - result_valid=1 and state=DONE; result_ack returns to IDLE with result_valid=0.
- cmd_run straight after reset:
  - Expect state stays IDLE, err=1, no writes.
  - Then cmd_load: err=0 on the accept edge.
- data_valid during EVAL, and cmd_load during LOAD_I:
  - Expect no extra writes, capture still on schedule, err=1.
- Assert rst_n low after 10 of 24 parameter bytes:
  - Expect all outputs 0 immediately (asynchronous), params_ok=0.
  - A fresh full load then succeeds with addr restarting at 0.
- In DONE, cmd_run:
  - Expect result_valid=0 on the next edge, state=LOAD_I, in_addr=0 for the next input.
- Simultaneous cmd_load and cmd_run in IDLE:
  - Expect LOAD_P entered, err unchanged.
